rf_port_arbiter: RTL and testbench
==================================

# rf_port_arbiter

Sequencer and two-way arbiter for the 4x8-bit register file's single shared port. It accepts read or write commands from two requesters (0: core datapath, 1: debug/loader), grants one at a time, drives the register file's read/write enable and address/data lines for exactly one cycle, and returns read data with a completion pulse. It sits between the requesters and `register_file`; it is the only block that drives that module's control inputs.

## Interface
- `NREQ` = 2: number of requesters. Fixed; no other value is supported.
- `DW` = 8: data width.
- `clk` in 1: system clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req[1:0]` in 2: per-requester request. Hold high, with the command stable, until `gnt[i]` is sampled high.
- `we[1:0]` in 2: per-requester command type; 1 = write, 0 = read.
- `waddr0`, `waddr1` in 2 each: write register address.
- `raddr1_0`, `raddr2_0`, `raddr1_1`, `raddr2_1` in 2 each: read addresses, two per requester.
- `wdata0`, `wdata1` in 8 each: write data.
- `gnt[1:0]` out 2: combinational, one-hot or zero; the command is accepted on the rising edge where `gnt[i]`=1.
- `done[1:0]` out 2: registered one-cycle completion pulse to the owner.
- `rdata1`, `rdata2` out 8 each: registered read results. Valid when `done` is high; held until the next read completes.
- `rf_ren_wen` out 1: register file enable; 1 = write, 0 = read.
- `rf_writeaddr`, `rf_readaddr1`, `rf_readaddr2` out 2 each: register file addresses.
- `acc` out 8: register file write data.
- `rf_data1`, `rf_data2` in 8 each: register file read data. It is registered inside the file and updates on the edge that ends a read cycle.

## Operation
- FSM states are IDLE, ISSUE, CAPT and RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req` is high, assert `gnt` for the winner.
  - On the edge, latch the winner's command into internal registers (`owner`, `we`, addresses, data) and go to ISSUE.
  - If no `req` is high, `gnt`=0 and the FSM stays in IDLE.
- **ISSUE:**
  - Drive `rf_ren_wen` = latched `we` and drive the latched addresses and `acc` for exactly this cycle.
  - If `we`=1, go to RESP. If `we`=0, go to CAPT.
- **CAPT (reads only):**
  - `rf_ren_wen`=0 and the addresses stay at the latched values.
  - On the edge, `rdata1`/`rdata2` <= `rf_data1`/`rf_data2`, then go to RESP.
- **RESP:** `done[owner]`=1 for this cycle, `gnt`=0, then go to IDLE. Requests raised during RESP are arbitrated in the following IDLE.
- **Outside ISSUE:** `rf_ren_wen`=0, `acc`=0, and the addresses are the latched values.
- **Arbitration:** round-robin with a `last` register. On a simultaneous request, grant the requester that is not `last`. `last` updates on every grant. Reset value of `last` is 1, so requester 0 wins the first tie. A lone request always wins.
- **Address 0:** reads of address 0 return 0 because the register file forces it. Writes to address 0 are issued unchanged, and `done` still pulses.
- **Dropped requests:** deasserting `req` before grant is legal and has no effect.
- **Reset:** asynchronous assertion mid-transaction aborts it. The FSM goes to IDLE, no `done` is emitted, and all outputs take their reset values. A write in ISSUE at the reset edge is not guaranteed to land.

## Timing
- **Reset values:** `gnt`=0, `done`=0, `rdata1`=`rdata2`=0, `rf_ren_wen`=0, all `rf_*addr`=0, `acc`=0, `last`=1.
- **Write:** grant in cycle G, ISSUE in G+1, the register file updates at the end of G+1, `done` in G+2.
- **Read:** grant in G, ISSUE in G+1, CAPT in G+2, `done` with valid `rdata` in G+3.
- **Throughput:** one write per 3 cycles, one read per 4 cycles.
- **Combinational paths:** `gnt` is combinational from `req` and state only. No combinational path exists from `rf_data*` to any output.

## Configuration
- `RF_ARB_FIXED_PRIO_EN`:
  - **Defined:** fixed priority, requester 0 always wins ties. The `last` register is removed; `gnt[1]` only when `req[0]`=0.
  - **Undefined (default):** round-robin as specified above.

## Test plan
- **Reset:** reset_n=0 -> all outputs 0; after release with no `req`, the FSM stays in IDLE and `rf_ren_wen` stays 0.
- **Write then read:** requester 0 writes 8'hA5 to reg 2, then reads raddr1=2, raddr2=0 -> `rf_ren_wen`=1 only in the ISSUE cycle, `done[0]` at G+2; the read gives `done[0]` at G+3 with `rdata1`=8'hA5, `rdata2`=8'h00.
- **Tie:** both requesters hold `req` continuously with reads -> grants alternate 0,1,0,1. With `RF_ARB_FIXED_PRIO_EN` defined -> requester 0 every time.
- **Lone request:** requester 1 alone writes 8'h3C to reg 3, then requester 0 reads reg 3 -> `gnt[1]` immediately, then `rdata1`=8'h3C, `done` only on the owner's bit.
- **Reset mid-read:** pull `reset_n` low during CAPT -> no `done` pulse, `rdata` back to 0, state IDLE. The next request is served normally with the round-robin pointer back at `last`=1.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: two-requester sequencer for the shared register-file port.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module rf_port_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] we,
    input  logic [1:0]      waddr0,
    input  logic [1:0]      waddr1,
    input  logic [1:0]      raddr1_0,
    input  logic [1:0]      raddr2_0,
    input  logic [1:0]      raddr1_1,
    input  logic [1:0]      raddr2_1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic [DW-1:0]   rdata1,
    output logic [DW-1:0]   rdata2,
    output logic            rf_ren_wen,
    output logic [1:0]      rf_writeaddr,
    output logic [1:0]      rf_readaddr1,
    output logic [1:0]      rf_readaddr2,
    output logic [DW-1:0]   acc,
    input  logic [DW-1:0]   rf_data1,
    input  logic [DW-1:0]   rf_data2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            any_req;
    logic            win;
    logic            owner;
    logic            we_q;
    logic [1:0]      wa_q;
    logic [1:0]      ra1_q;
    logic [1:0]      ra2_q;
    logic [DW-1:0]   wd_q;
    logic [NREQ-1:0] owner_oh;

    assign any_req  = |req;
    assign owner_oh = owner ? NREQ'(2'b10) : NREQ'(2'b01);

`ifdef RF_ARB_FIXED_PRIO_EN
    assign win = ~req[0];
`else
    logic last;

    // On a tie the requester that did not win last time goes first.
    assign win = (req[0] & req[1]) ? ~last : req[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last <= win;
        end
    end
`endif

    always_comb begin
        gnt = '0;
        if (state == IDLE && any_req) begin
            gnt = win ? NREQ'(2'b10) : NREQ'(2'b01);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (any_req) state_nxt = ISSUE;
            ISSUE: state_nxt = we_q ? RESP : CAPT;
            CAPT:  state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner <= 1'b0;
            we_q  <= 1'b0;
            wa_q  <= '0;
            ra1_q <= '0;
            ra2_q <= '0;
            wd_q  <= '0;
        end else if (state == IDLE && any_req) begin
            owner <= win;
            we_q  <= win ? we[1] : we[0];
            wa_q  <= win ? waddr1 : waddr0;
            ra1_q <= win ? raddr1_1 : raddr1_0;
            ra2_q <= win ? raddr2_1 : raddr2_0;
            wd_q  <= win ? wdata1 : wdata0;
        end
    end

    // Read data is sampled only at the end of CAPT, so rf_data never
    // reaches an output combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata1 <= '0;
            rdata2 <= '0;
            done   <= '0;
        end else begin
            if (state == CAPT) begin
                rdata1 <= rf_data1;
                rdata2 <= rf_data2;
            end
            done <= (state_nxt == RESP) ? owner_oh : '0;
        end
    end

    always_comb begin
        rf_ren_wen   = 1'b0;
        acc          = '0;
        rf_writeaddr = wa_q;
        rf_readaddr1 = ra1_q;
        rf_readaddr2 = ra2_q;
        if (state == ISSUE) begin
            rf_ren_wen = we_q;
            acc        = wd_q;
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed-vector bench for rf_port_arbiter with a behavioural register file.
// Expectations follow RF_ARB_FIXED_PRIO_EN when it is defined.
module tb_rf_port_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] waddr0, waddr1;
    logic [1:0] raddr1_0, raddr2_0, raddr1_1, raddr2_1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] gnt, done;
    logic [7:0] rdata1, rdata2;
    logic       rf_ren_wen;
    logic [1:0] rf_writeaddr, rf_readaddr1, rf_readaddr2;
    logic [7:0] acc;
    logic [7:0] rf_data1, rf_data2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rf_port_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we),
        .waddr0(waddr0), .waddr1(waddr1),
        .raddr1_0(raddr1_0), .raddr2_0(raddr2_0),
        .raddr1_1(raddr1_1), .raddr2_1(raddr2_1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata1(rdata1), .rdata2(rdata2),
        .rf_ren_wen(rf_ren_wen), .rf_writeaddr(rf_writeaddr),
        .rf_readaddr1(rf_readaddr1), .rf_readaddr2(rf_readaddr2),
        .acc(acc), .rf_data1(rf_data1), .rf_data2(rf_data2)
    );

    // Register file: register 0 reads as zero, read data registered.
    logic [7:0] mem [4] = '{default: 8'h00};
    always @(posedge clk) begin
        if (rf_ren_wen) mem[rf_writeaddr] <= acc;
        rf_data1 <= (rf_readaddr1 == 2'd0) ? 8'h00 : mem[rf_readaddr1];
        rf_data2 <= (rf_readaddr2 == 2'd0) ? 8'h00 : mem[rf_readaddr2];
    end

    typedef struct {
        int         id;
        logic       wr;
        logic [1:0] wa;
        logic [1:0] r1;
        logic [1:0] r2;
        logic [7:0] wd;
        logic [1:0] eg;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic set_cmd(input int id, input logic wr, input logic [1:0] wa,
                           input logic [1:0] r1, input logic [1:0] r2,
                           input logic [7:0] wd);
        if (id == 0) begin
            we[0] = wr; waddr0 = wa; raddr1_0 = r1; raddr2_0 = r2; wdata0 = wd;
        end else begin
            we[1] = wr; waddr1 = wa; raddr1_1 = r1; raddr2_1 = r2; wdata1 = wd;
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        set_cmd(v.id, v.wr, v.wa, v.r1, v.r2, v.wd);
        req = (v.id == 0) ? 2'b01 : 2'b10;
        #1 chk("gnt", gnt, v.eg);
        @(posedge clk); #1;
        req = 2'b00;
        chk("issue_wen", rf_ren_wen, v.wr);
        chk("issue_acc", acc, v.wr ? v.wd : 8'h00);
        chk("issue_done", done, 2'b00);
        if (v.wr) begin
            chk("issue_waddr", rf_writeaddr, v.wa);
        end else begin
            chk("issue_raddr1", rf_readaddr1, v.r1);
            chk("issue_raddr2", rf_readaddr2, v.r2);
            @(posedge clk); #1;
            chk("capt_wen", rf_ren_wen, 1'b0);
            chk("capt_done", done, 2'b00);
        end
        @(posedge clk); #1;
        chk("resp_done", done, (v.id == 0) ? 2'b01 : 2'b10);
        chk("resp_wen", rf_ren_wen, 1'b0);
        chk("resp_acc", acc, 8'h00);
        chk("resp_rdata1", rdata1, v.e1);
        chk("resp_rdata2", rdata2, v.e2);
        @(posedge clk); #1;
        chk("idle_done", done, 2'b00);
    endtask

    logic [1:0] tie_exp [4];
    logic [1:0] g;
    int n;

    initial begin
        //           id wr wa    r1    r2    wd     eg     e1     e2
        vecs[0] = '{0, 1, 2'd2, 2'd0, 2'd0, 8'hA5, 2'b01, 8'h00, 8'h00};
        vecs[1] = '{0, 0, 2'd0, 2'd2, 2'd0, 8'h00, 2'b01, 8'hA5, 8'h00};
        vecs[2] = '{1, 1, 2'd3, 2'd0, 2'd0, 8'h3C, 2'b10, 8'hA5, 8'h00};
        vecs[3] = '{0, 0, 2'd0, 2'd3, 2'd2, 8'h00, 2'b01, 8'h3C, 8'hA5};
        vecs[4] = '{1, 1, 2'd0, 2'd0, 2'd0, 8'h5A, 2'b10, 8'h3C, 8'hA5};
        vecs[5] = '{1, 0, 2'd0, 2'd0, 2'd3, 8'h00, 2'b10, 8'h00, 8'h3C};
        vecs[6] = '{0, 1, 2'd1, 2'd0, 2'd0, 8'hFF, 2'b01, 8'h00, 8'h3C};
        vecs[7] = '{1, 0, 2'd0, 2'd1, 2'd1, 8'h00, 2'b10, 8'hFF, 8'hFF};
        vecs[8] = '{0, 0, 2'd0, 2'd2, 2'd3, 8'h00, 2'b01, 8'hA5, 8'h3C};
`ifdef RF_ARB_FIXED_PRIO_EN
        tie_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        reset_n = 1'b0;
        req = 2'b00; we = 2'b00;
        waddr0 = 0; waddr1 = 0;
        raddr1_0 = 0; raddr2_0 = 0; raddr1_1 = 0; raddr2_1 = 0;
        wdata0 = 0; wdata1 = 0;
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_rdata", {rdata1, rdata2}, 16'h0000);
        chk("rst_wen", rf_ren_wen, 1'b0);
        chk("rst_addr", {rf_writeaddr, rf_readaddr1, rf_readaddr2}, 6'd0);
        chk("rst_acc", acc, 8'h00);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("quiet_wen", rf_ren_wen, 1'b0);
            chk("quiet_done", done, 2'b00);
        end

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Request dropped before any edge sees it.
        @(negedge clk);
        set_cmd(1, 1'b1, 2'd2, 2'd0, 2'd0, 8'h77);
        req = 2'b10;
        #1 chk("drop_gnt", gnt, 2'b10);
        #2 req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("drop_wen", rf_ren_wen, 1'b0);
            chk("drop_done", done, 2'b00);
        end
        run_vec(vecs[8]);

        // Reset during CAPT of a requester-0 read.
        @(negedge clk);
        set_cmd(0, 1'b0, 2'd0, 2'd1, 2'd1, 8'h00);
        req = 2'b01;
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;
        chk("mid_in_capt_wen", rf_ren_wen, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_done", done, 2'b00);
        chk("mid_rdata", {rdata1, rdata2}, 16'h0000);
        chk("mid_addr", {rf_writeaddr, rf_readaddr1, rf_readaddr2}, 6'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_nodone", done, 2'b00);
        end

        // Both requesters hold read requests continuously.
        @(negedge clk);
        set_cmd(0, 1'b0, 2'd0, 2'd2, 2'd0, 8'h00);
        set_cmd(1, 1'b0, 2'd0, 2'd3, 2'd1, 8'h00);
        req = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (gnt == 2'b00 && n < 12) begin
                @(negedge clk); #1; n++;
            end
            chk("tie_gnt", gnt, tie_exp[k]);
            g = tie_exp[k];
            n = 0;
            do begin
                @(negedge clk); #1; n++;
            end while (done == 2'b00 && n < 12);
            chk("tie_done", done, g);
            chk("tie_rdata1", rdata1, (g == 2'b10) ? 8'h3C : 8'hA5);
        end
        req = 2'b00;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
